// File: rtl/sc_mac_sequencer.sv
// sc_mac_sequencer: control sequencer for a stochastic-computing MAC.
// For each product term it strobes the operand registers (LOAD), then
// streams one full bitstream epoch of 2^CNT_WIDTH cycles (STREAM) while
// the accumulator integrates product bits, and finally pulses done.
// All outputs are registered and updated together with the state.
module sc_mac_sequencer #(
    parameter int CNT_WIDTH  = 7,
    parameter int TERM_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TERM_WIDTH-1:0] num_terms,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  load_op,
    output logic                  sn_en,
    output logic [CNT_WIDTH-1:0]  phase,
    output logic [TERM_WIDTH-1:0] term_idx,
    output logic                  acc_clr,
    output logic                  acc_en
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  PHASE_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  PHASE_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  PHASE_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TERM_WIDTH-1:0] TERM_ZERO  = {TERM_WIDTH{1'b0}};
    localparam logic [TERM_WIDTH-1:0] TERM_ONE   = {{(TERM_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [TERM_WIDTH-1:0] count_r;
    logic                  last_term_s;

    // The captured count is never zero while streaming, so count_r-1 is the final index.
    assign last_term_s = (term_idx == (count_r - TERM_ONE));

    // Sequencer state machine with all control outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            // Reset and abort both return to a quiet IDLE; reset wins by sharing the same path.
            state_r  <= IDLE;
            count_r  <= TERM_ZERO;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_op  <= 1'b0;
            sn_en    <= 1'b0;
            acc_en   <= 1'b0;
            acc_clr  <= 1'b0;
            phase    <= PHASE_ZERO;
            term_idx <= TERM_ZERO;
        end else begin
            // Single-cycle strobes default low and are raised only on the cycle they apply to.
            done    <= 1'b0;
            load_op <= 1'b0;
            acc_clr <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        acc_clr  <= 1'b1;
                        phase    <= PHASE_ZERO;
                        term_idx <= TERM_ZERO;
                        count_r  <= num_terms;
                        if (num_terms != TERM_ZERO) begin
                            state_r <= LOAD;
                            load_op <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r <= STREAM;
                    sn_en   <= 1'b1;
                    acc_en  <= 1'b1;
                    phase   <= PHASE_ZERO;
                end
                STREAM: begin
                    if (phase == PHASE_MAX) begin
                        sn_en  <= 1'b0;
                        acc_en <= 1'b0;
                        phase  <= PHASE_ZERO;
                        if (last_term_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r  <= LOAD;
                            load_op  <= 1'b1;
                            term_idx <= term_idx + TERM_ONE;
                        end
                    end else begin
                        phase <= phase + PHASE_ONE;
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    sn_en    <= 1'b0;
                    acc_en   <= 1'b0;
                    phase    <= PHASE_ZERO;
                    term_idx <= TERM_ZERO;
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    sn_en    <= 1'b0;
                    acc_en   <= 1'b0;
                    phase    <= PHASE_ZERO;
                    term_idx <= TERM_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mac_sequencer.sv
// Scoreboard bench for sc_mac_sequencer. The driver pushes the full
// expected per-cycle output trace of every run into a queue; a monitor
// pops one record per cycle and compares it with the DUT outputs
// (an empty queue means the DUT must sit quietly in IDLE).
module tb_sc_mac_sequencer;

    localparam int CW    = 7;
    localparam int TW    = 4;
    localparam int EPOCH = 1 << CW;

    typedef struct {
        logic          busy;
        logic          done;
        logic          load_op;
        logic          sn_en;
        logic          acc_en;
        logic          acc_clr;
        logic [CW-1:0] phase;
        logic [TW-1:0] term_idx;
        logic          chk_term;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] num_terms = '0;
    logic          abort = 1'b0;
    logic          busy, done, load_op, sn_en, acc_en, acc_clr;
    logic [CW-1:0] phase;
    logic [TW-1:0] term_idx;

    rec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    sc_mac_sequencer #(.CNT_WIDTH(CW), .TERM_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms), .abort(abort),
        .busy(busy), .done(done), .load_op(load_op), .sn_en(sn_en), .phase(phase),
        .term_idx(term_idx), .acc_clr(acc_clr), .acc_en(acc_en)
    );

    always #5 clk = ~clk;

    function automatic int run_len(int n);
        return (n == 0) ? 1 : n * (EPOCH + 1) + 1;
    endfunction

    // Expected outputs c cycles after the start-sampling edge, from plain arithmetic.
    function automatic rec_t model(int n, int c);
        rec_t r;
        int   k, m;
        r.busy = 1'b1; r.done = 1'b0; r.load_op = 1'b0; r.sn_en = 1'b0;
        r.acc_en = 1'b0; r.acc_clr = (c == 1); r.phase = '0; r.term_idx = '0;
        r.chk_term = 1'b1;
        if (c == run_len(n)) begin
            r.done = 1'b1;
            r.chk_term = (n == 0);
        end else begin
            k = (c - 1) / (EPOCH + 1);
            m = (c - 1) % (EPOCH + 1);
            r.term_idx = TW'(k);
            if (m == 0) r.load_op = 1'b1;
            else begin
                r.sn_en = 1'b1; r.acc_en = 1'b1; r.phase = CW'(m - 1);
            end
        end
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r.busy = 1'b0; r.done = 1'b0; r.load_op = 1'b0; r.sn_en = 1'b0;
        r.acc_en = 1'b0; r.acc_clr = 1'b0; r.phase = '0; r.term_idx = '0;
        r.chk_term = 1'b1;
        return r;
    endfunction

    // Monitor: compare every cycle, just after the rising edge.
    initial begin
        rec_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
                bad = (busy !== e.busy) || (done !== e.done) || (load_op !== e.load_op) ||
                      (sn_en !== e.sn_en) || (acc_en !== e.acc_en) || (acc_clr !== e.acc_clr) ||
                      (phase !== e.phase) || (e.chk_term && (term_idx !== e.term_idx));
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL cycle_outputs t=%0t got busy=%b done=%b ld=%b sn=%b acc=%b clr=%b ph=%0d ti=%0d exp busy=%b done=%b ld=%b sn=%b acc=%b clr=%b ph=%0d ti=%0d",
                             $time, busy, done, load_op, sn_en, acc_en, acc_clr, phase, term_idx,
                             e.busy, e.done, e.load_op, e.sn_en, e.acc_en, e.acc_clr, e.phase, e.term_idx);
                end
            end
        end
    end

    // One run of n terms; cut_at>0 asserts abort (or rst if use_rst) during that cycle.
    // Random start pulses with random num_terms are injected while busy when noisy is set.
    task automatic do_run(input int n, input int cut_at, input bit use_rst, input bit noisy);
        int len;
        int last;
        len  = run_len(n);
        last = (cut_at > 0) ? cut_at : len;
        @(negedge clk);
        start = 1'b1;
        num_terms = TW'(n);
        for (int c = 1; c <= last; c++) exp_q.push_back(model(n, c));
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            num_terms = noisy ? TW'($urandom_range(0, 15)) : TW'(n);
            if (j == cut_at) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        num_terms = TW'($urandom_range(0, 15));
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int n;
        int cut;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;          // reset state is checked while rst is still high
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);

        do_run(1, 0, 1'b0, 1'b0);                     // single term
        idle_cycles(3);
        do_run(3, 0, 1'b0, 1'b0);                     // multi-term
        idle_cycles(2);
        do_run(0, 0, 1'b0, 1'b0);                     // zero terms
        idle_cycles(2);
        do_run(3, 2 + (EPOCH + 1) + 50, 1'b0, 1'b0);  // abort at phase 50 of term 1
        idle_cycles(2);
        do_run(7, 0, 1'b0, 1'b1);                     // start/num_terms noise while busy
        idle_cycles(2);
        do_run(2, 60, 1'b1, 1'b0);                    // reset mid-stream
        do_run(1, 0, 1'b0, 1'b0);                     // first start after reset
        idle_cycles(2);

        // abort together with start in IDLE: no run may begin
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_terms = 4'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        idle_cycles(2);

        do_run(15, 0, 1'b0, 1'b0);                    // largest term count
        idle_cycles(1);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 4);
            cut = ($urandom_range(0, 2) == 0) ? $urandom_range(1, run_len(n)) : 0;
            do_run(n, cut, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(4);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain got %0d pending records, exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
